load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: RD_WAIT, 0, extra cycles mem_read is held before mem_dout is sampled (range 0..15).
REQ-002 SHALL have port: clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req_valid in 1 request present; req_ready out 1 unit can accept.
REQ-005 SHALL have ports: req_write in 1 store=1/load=0; req_size in 2 (00 byte, 01 half, 10 word, 11 illegal); req_unsigned in 1 zero-extend loads.
REQ-006 SHALL have ports: req_addr in 32 byte address; req_wdata in 32 store data, LSB-aligned.
REQ-007 SHALL have ports: resp_valid out 1 one-cycle completion pulse; resp_rdata out 32 load result; resp_error out 1 misaligned/illegal.
REQ-008 SHALL have memory-side ports: mem_addr out 32; mem_din out 32; mem_read out 1; mem_write out 1; mem_dout in 32 (async-read, sync-write word memory, word index = mem_addr>>2).

Function
REQ-009 SHALL implement states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-010 SHALL accept a request on a cycle with req_valid && req_ready, registering all req_* fields.
REQ-011 SHALL flag error when req_size=11, half with addr[0]=1, or word with addr[1:0]!=0; error goes IDLE->RESP with no memory access.
REQ-012 SHALL drive mem_addr = {addr[31:2],2'b00} in READ/WRITE, 0 otherwise.
REQ-013 Load: IDLE->READ; mem_read=1 for RD_WAIT+1 cycles (counter); capture mem_dout on the last; ->RESP.
REQ-014 Load result: select byte addr[1:0] or half addr[1]; sign-extend unless req_unsigned; word passes through.
REQ-015 Word store: IDLE->WRITE; mem_write=1, mem_din=wdata for exactly one cycle; ->RESP.
REQ-016 Byte/half store: read-modify-write: READ (as REQ-013), then WRITE with captured word with only the addressed lanes replaced by wdata low bits.
REQ-017 Latency from accept cycle T to resp_valid: error T+1; word store T+2; load T+2+RD_WAIT; sub-word store T+3+RD_WAIT.
REQ-018 RESP SHALL last one cycle then return IDLE; resp_rdata/resp_error valid only while resp_valid, 0 otherwise; resp_rdata=0 for stores and errors.
REQ-019 mem_read and mem_write SHALL never be high in the same cycle; both 0 in IDLE and RESP.
REQ-020 req_valid asserted outside IDLE SHALL be ignored (not queued); requester holds it until req_ready.

Reset
REQ-021 On reset: state IDLE, counter 0, captured data 0; next cycle req_ready=1, all other outputs 0.
REQ-022 mem_read and mem_write SHALL be forced 0 combinationally whenever reset is high, including reset mid-READ/WRITE; any in-flight request is dropped with no resp_valid.

Structure
REQ-023 Shared package SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-024 Lane extraction/extension and store-merge SHALL live in one combinational sub-module lsu_align; FSM, counter, registers in load_store_unit.

Verification (bench pairs unit with the word memory, RD_WAIT=0 and 2)
REQ-025 Word store 0xDEADBEEF @0x100, then word load @0x100 -> single mem_write at T+1, resp_rdata=0xDEADBEEF at T+2+RD_WAIT.
REQ-026 Memory word @0x200=0x11223344; signed byte load @0x203 -> 0x00000011; @0x200 half signed after storing 0x8000 -> 0xFFFF8000, unsigned -> 0x00008000.
REQ-027 Byte store 0xAB @0x201 over 0x11223344 -> one read then one write, word becomes 0x1122AB44, resp at T+3+RD_WAIT.
REQ-028 Half load @0x101, word store @0x102, req_size=11 -> resp_error=1 at T+1, no mem_read/mem_write asserted.
REQ-029 Reset asserted during WRITE of sub-word store -> mem_write=0 that cycle, memory unchanged, no resp_valid, req_ready=1 after.
REQ-030 Back-to-back req_valid held high for 4 requests -> each accepted only in IDLE, responses in order, mem_read&&mem_write never both 1.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment rule that decides whether a request is rejected up front.
package load_store_unit_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } lsu_state_t;

    // Misaligned half/word or an illegal size never touches memory.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts and extends the addressed lane of a memory word
// for loads, and merges store data into the addressed lanes for stores.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = mem_word[7:0];
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            default: byte_sel = mem_word[31:24];
        endcase
        half_sel = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    end

    always_comb begin
        load_data  = '0;
        store_word = mem_word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
                store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SZ_WORD: begin
                load_data  = mem_word;
                store_word = wdata;
            end
            default: begin
                load_data  = '0;
                store_word = mem_word;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of an async-read, sync-write word
// memory; sub-word stores are done as read-modify-write.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int RD_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);

    localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);

    lsu_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic [31:0] word_q, word_d;

    logic [31:0] load_data;
    logic [31:0] store_word;

    lsu_align u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .addr_lo     (addr_q[1:0]),
        .mem_word    (word_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            write_q <= write_d;
            err_q   <= err_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        write_d = write_q;
        err_d   = err_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    write_d = req_write;
                    err_d   = req_bad(req_size, req_addr[1:0]);
                    cnt_d   = '0;
                    word_d  = '0;
                    if (req_bad(req_size, req_addr[1:0])) begin
                        state_d = RESP;
                    end else if (req_write && req_size == SZ_WORD) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                // Sample the memory only on the last held cycle of mem_read.
                if (cnt_q == RD_WAIT_C) begin
                    word_d  = mem_dout;
                    cnt_d   = '0;
                    state_d = write_q ? WRITE : RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        // Reset kills memory strobes immediately, before the state register clears.
        mem_read   = (state_q == READ) && !reset;
        mem_write  = (state_q == WRITE) && !reset;
        mem_addr   = '0;
        mem_din    = '0;
        if (state_q == READ || state_q == WRITE) begin
            mem_addr = {addr_q[31:2], 2'b00};
        end
        if (state_q == WRITE) begin
            mem_din = store_word;
        end
        resp_valid = (state_q == RESP);
        resp_error = (state_q == RESP) && err_q;
        resp_rdata = '0;
        if (state_q == RESP && !write_q && !err_q) begin
            resp_rdata = load_data;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Pairs two load/store units (RD_WAIT 0 and 2) with one word memory and checks
// responses, latencies and memory traffic against a scoreboard.
module tb_load_store_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        int          rd;
        int          wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        r0_ready, r0_rvld, r0_rerr, r0_mrd, r0_mwr;
    logic [31:0] r0_rdata, r0_maddr, r0_mdin;
    logic        r1_ready, r1_rvld, r1_rerr, r1_mrd, r1_mwr;
    logic [31:0] r1_rdata, r1_maddr, r1_mdin;

    logic        req_ready, resp_valid, resp_error, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;

    logic [31:0] mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_idx = '0;
    logic [31:0] pre_dat = '0;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   rd_n = 0;
    int   wr_n = 0;
    int   wr_cyc = 0;
    int   w;
    logic both_seen = 1'b0;
    logic idle_junk = 1'b0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_store_unit #(.RD_WAIT(0)) u_lsu0 (
        .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(r0_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(r0_rvld),
        .resp_rdata(r0_rdata), .resp_error(r0_rerr), .mem_addr(r0_maddr),
        .mem_din(r0_mdin), .mem_read(r0_mrd), .mem_write(r0_mwr), .mem_dout(mem_dout)
    );

    load_store_unit #(.RD_WAIT(2)) u_lsu1 (
        .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(r1_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(r1_rvld),
        .resp_rdata(r1_rdata), .resp_error(r1_rerr), .mem_addr(r1_maddr),
        .mem_din(r1_mdin), .mem_read(r1_mrd), .mem_write(r1_mwr), .mem_dout(mem_dout)
    );

    assign req_ready  = sel ? r1_ready : r0_ready;
    assign resp_valid = sel ? r1_rvld  : r0_rvld;
    assign resp_rdata = sel ? r1_rdata : r0_rdata;
    assign resp_error = sel ? r1_rerr  : r0_rerr;
    assign mem_addr   = sel ? r1_maddr : r0_maddr;
    assign mem_din    = sel ? r1_mdin  : r0_mdin;
    assign mem_read   = sel ? r1_mrd   : r0_mrd;
    assign mem_write  = sel ? r1_mwr   : r0_mwr;
    assign mem_dout   = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[11:2]] <= mem_din;
        else if (pre_we) mem[pre_idx] <= pre_dat;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: pops one expectation per completion pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_n = 0;
                wr_n = 0;
            end else begin
                if (mem_read) rd_n++;
                if (mem_write) begin
                    wr_n++;
                    wr_cyc = cyc;
                end
                if (mem_read && mem_write) both_seen = 1'b1;
                if (!resp_valid && (resp_rdata != 0 || resp_error)) idle_junk = 1'b1;
                if (resp_valid) begin
                    if (sbq.size() == 0) begin
                        check("spurious_resp", 32'd1, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        check("resp_rdata", resp_rdata, e.rdata);
                        check("resp_error", {31'd0, resp_error}, {31'd0, e.err});
                        check("resp_cycle", 32'(cyc), 32'(e.due));
                        check("read_cycles", 32'(rd_n), 32'(e.rd));
                        check("write_cycles", 32'(wr_n), 32'(e.wr));
                        if (e.wr != 0) check("write_cycle_pos", 32'(wr_cyc), 32'(e.due - 1));
                    end
                    rd_n = 0;
                    wr_n = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdat,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat,
                        input int n_rd, input int n_wr, input logic keep);
        exp_t e;
        int n = 0;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdat;
        req_valid    = 1'b1;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.due   = cyc + lat;
        e.rd    = n_rd;
        e.wr    = n_wr;
        sbq.push_back(e);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sbq.size()), 32'd0);
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] dat);
        @(negedge clk);
        pre_idx = idx;
        pre_dat = dat;
        pre_we  = 1'b1;
        @(negedge clk);
        pre_we  = 1'b0;
    endtask

    initial begin
        int n;
        reset        = 1'b1;
        sel          = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        for (int p = 0; p < 2; p++) begin
            sel = p[0];
            w   = (p == 0) ? 0 : 2;
            reset = 1'b1;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check("rst_ready", {31'd0, req_ready}, 32'd1);
            check("rst_outs", {26'd0, resp_valid, resp_error, mem_read, mem_write, 2'b00}, 32'd0);
            check("rst_mem_addr", mem_addr | mem_din | resp_rdata, 32'd0);
            preload(10'd128, 32'h1122_3344);

            send(1, SZ_WORD_T(), 0, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 2, 0, 1, 0);
            drain();
            send(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 2 + w, w + 1, 0, 0);
            drain();
            send(0, 2'b00, 0, 32'h203, 32'h0, 32'h0000_0011, 0, 2 + w, w + 1, 0, 0);
            drain();
            send(0, 2'b00, 0, 32'h202, 32'h0, 32'h0000_0022, 0, 2 + w, w + 1, 0, 0);
            drain();
            send(1, 2'b00, 0, 32'h201, 32'hFFFF_FFAB, 32'h0, 0, 3 + w, w + 1, 1, 0);
            drain();
            check("mem_byte_rmw", mem[128], 32'h1122_AB44);
            send(1, 2'b01, 0, 32'h200, 32'h0000_8000, 32'h0, 0, 3 + w, w + 1, 1, 0);
            drain();
            check("mem_half_rmw", mem[128], 32'h1122_8000);
            send(0, 2'b01, 0, 32'h200, 32'h0, 32'hFFFF_8000, 0, 2 + w, w + 1, 0, 0);
            send(0, 2'b01, 1, 32'h200, 32'h0, 32'h0000_8000, 0, 2 + w, w + 1, 0, 0);
            drain();
            send(1, 2'b01, 0, 32'h202, 32'h1234_FF80, 32'h0, 0, 3 + w, w + 1, 1, 0);
            drain();
            check("mem_half_hi", mem[128], 32'hFF80_8000);
            send(0, 2'b00, 0, 32'h203, 32'h0, 32'hFFFF_FFFF, 0, 2 + w, w + 1, 0, 0);
            send(0, 2'b00, 1, 32'h203, 32'h0, 32'h0000_00FF, 0, 2 + w, w + 1, 0, 0);
            send(0, 2'b01, 0, 32'h202, 32'h0, 32'hFFFF_FF80, 0, 2 + w, w + 1, 0, 0);
            send(0, 2'b00, 0, 32'h201, 32'h0, 32'hFFFF_FF80, 0, 2 + w, w + 1, 0, 0);
            drain();

            send(0, 2'b01, 0, 32'h101, 32'h0, 32'h0, 1, 1, 0, 0, 0);
            send(1, 2'b10, 0, 32'h102, 32'h5555_5555, 32'h0, 1, 1, 0, 0, 0);
            send(0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 1, 1, 0, 0, 0);
            drain();
            check("mem_err_untouched", mem[64], 32'hDEAD_BEEF);

            // Valid held high across four requests.
            send(1, 2'b10, 0, 32'h300, 32'hCAFE_F00D, 32'h0, 0, 2, 0, 1, 1);
            send(0, 2'b10, 0, 32'h300, 32'h0, 32'hCAFE_F00D, 0, 2 + w, w + 1, 0, 1);
            send(0, 2'b00, 0, 32'h301, 32'h0, 32'hFFFF_FFF0, 0, 2 + w, w + 1, 0, 1);
            send(1, 2'b11, 0, 32'h300, 32'h0, 32'h0, 1, 1, 0, 0, 0);
            drain();

            // Reset while a sub-word store is in its write cycle.
            req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
            req_addr = 32'h200; req_wdata = 32'h55; req_valid = 1'b1;
            n = 0;
            while (!req_ready && n < 100) begin @(negedge clk); n++; end
            @(negedge clk);
            req_valid = 1'b0;
            n = 0;
            while (!mem_write && n < 40) begin @(negedge clk); n++; end
            check("reached_write", {31'd0, mem_write}, 32'd1);
            reset = 1'b1;
            #1;
            check("rst_kills_write", {31'd0, mem_write}, 32'd0);
            check("rst_kills_read", {31'd0, mem_read}, 32'd0);
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check("rst_ready_after", {31'd0, req_ready}, 32'd1);
            check("rst_no_resp", {31'd0, resp_valid}, 32'd0);
            check("rst_mem_unchanged", mem[128], 32'hFF80_8000);

            check("rw_overlap", {31'd0, both_seen}, 32'd0);
            check("idle_resp_junk", {31'd0, idle_junk}, 32'd0);
            check("sb_empty", 32'(sbq.size()), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic [1:0] SZ_WORD_T();
        return 2'b10;
    endfunction

endmodule
